// File: rtl/uart_tx_serializer_param_pkg.sv
// Shared constants, FSM encoding and width helper for the UART transmit serializer.
package uart_tx_serializer_param_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_param_if.sv
// Valid/ready word handshake between the TX register/FIFO and the serializer.
interface uart_tx_serializer_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer_param_baud_counter.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 while enabled, flags the last and next-to-last cycle of a bit.
module uart_tx_serializer_param_baud_counter
  import uart_tx_serializer_param_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end_c,
  output logic bit_pre_end_c
);

  localparam int unsigned CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] count;

  // Clearing on acceptance phase-aligns bit timing to the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || (enable && (count == CNT_LAST))) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign bit_end_c     = enable && (count == CNT_LAST);
  assign bit_pre_end_c = enable && (count == CNT_PRE);

endmodule

// File: rtl/uart_tx_serializer_param.sv
// UART transmit serializer: frames a word (start, data LSB-first, optional parity, stop bits)
// and times each bit with an internal baud counter.
module uart_tx_serializer_param
  import uart_tx_serializer_param_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                         clk,
  input  logic                         rst,
  uart_tx_serializer_param_if.slave    bus,
  output logic                         tx,
  output logic                         busy,
  output logic                         tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY_MODE > PARITY_ODD) begin : g_bad_parity_mode
    $error("PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be >= 2");
  end

  localparam int unsigned IDX_W = clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  state_t               state, state_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 par_bit, par_bit_next;
  logic                 ready, ready_next;
  logic                 tx_next, busy_next, done_next;
  logic                 accept_c, bit_end_c, bit_pre_end_c;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == PARITY_ODD) ? ~^d : ^d;
  endfunction

  assign accept_c     = bus.tx_valid && ready;
  assign bus.tx_ready = ready;

  uart_tx_serializer_param_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk           (clk),
    .rst           (rst),
    .clear         (accept_c),
    .enable        (busy),
    .bit_end_c     (bit_end_c),
    .bit_pre_end_c (bit_pre_end_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      ready   <= 1'b1;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      par_bit <= par_bit_next;
      ready   <= ready_next;
      tx      <= tx_next;
      busy    <= busy_next;
      tx_done <= done_next;
    end
  end

  // Next-state and registered-output values; tx always carries the level of the upcoming cycle.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    par_bit_next = par_bit;
    ready_next   = ready;
    tx_next      = tx;
    busy_next    = busy;
    done_next    = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_next    = 1'b1;
        ready_next = 1'b1;
        busy_next  = 1'b0;
      end
      ST_START: begin
        if (bit_end_c) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
          tx_next      = shreg[0];
          shreg_next   = shreg >> 1;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          if (bit_idx == IDX_LAST_DATA) begin
            bit_idx_next = '0;
            if (HAS_PARITY) begin
              state_next = ST_PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
            tx_next      = shreg[0];
            shreg_next   = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          state_next   = ST_STOP;
          bit_idx_next = '0;
          tx_next      = 1'b1;
        end
      end
      ST_STOP: begin
        // Final cycle of the last stop bit: pulse done and open the handshake.
        if (bit_idx == IDX_LAST_STOP) begin
          if (bit_pre_end_c) begin
            done_next  = 1'b1;
            ready_next = 1'b1;
          end
          if (bit_end_c) begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            ready_next = 1'b1;
            tx_next    = 1'b1;
          end
        end else if (bit_end_c) begin
          bit_idx_next = bit_idx + IDX_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Acceptance (idle or last stop cycle) overrides: start bit begins on the next cycle.
    if (accept_c) begin
      state_next   = ST_START;
      bit_idx_next = '0;
      shreg_next   = bus.tx_data;
      par_bit_next = parity_of(bus.tx_data);
      tx_next      = 1'b0;
      ready_next   = 1'b0;
      busy_next    = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer_param.sv
// Self-checking bench: five serializer configurations, frames checked cycle by cycle against a scoreboard.
module tb_uart_tx_serializer_param;

  typedef struct {
    int          inst;
    int          nbits;
    logic [15:0] bits;
  } sb_t;

  logic       clk;
  logic       rst;
  logic [4:0] drv_valid;
  logic [8:0] drv_data [5];
  logic [4:0] mon_tx, mon_busy, mon_done, mon_ready;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;

  function automatic int unsigned cfg_db(input int g); return (g == 4) ? 5 : 8; endfunction
  function automatic int unsigned cfg_pm(input int g); return (g == 1) ? 1 : (g == 2) ? 2 : 0; endfunction
  function automatic int unsigned cfg_sb(input int g); return (g == 3) ? 2 : 1; endfunction
  function automatic int unsigned cfg_nc(input int g); return (g == 4) ? 2 : 4; endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop bits at 1.
  function automatic sb_t build_frame(input int g, input logic [8:0] d);
    sb_t  e;
    int   k;
    logic p;
    e.inst = g;
    e.bits = '1;
    p      = 1'b0;
    e.bits[0] = 1'b0;
    k = 1;
    for (int i = 0; i < int'(cfg_db(g)); i++) begin
      e.bits[4'(k)] = d[i];
      p = p ^ d[i];
      k++;
    end
    if (cfg_pm(g) != 0) begin
      e.bits[4'(k)] = (cfg_pm(g) == 1) ? p : ~p;
      k++;
    end
    k = k + int'(cfg_sb(g));
    e.nbits = k;
    return e;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 5; g++) begin : g_cfg
    localparam int unsigned DB = cfg_db(g);
    localparam int unsigned NC = cfg_nc(g);

    logic tx, busy, tx_done;

    uart_tx_serializer_param_if #(.DATA_BITS(DB)) u_if ();

    assign u_if.tx_data  = drv_data[g][DB-1:0];
    assign u_if.tx_valid = drv_valid[g];
    assign mon_tx[g]     = tx;
    assign mon_busy[g]   = busy;
    assign mon_done[g]   = tx_done;
    assign mon_ready[g]  = u_if.tx_ready;

    uart_tx_serializer_param #(
      .DATA_BITS    (DB),
      .PARITY_MODE  (cfg_pm(g)),
      .STOP_BITS    (cfg_sb(g)),
      .CLKS_PER_BIT (NC)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (u_if.slave),
      .tx      (tx),
      .busy    (busy),
      .tx_done (tx_done)
    );

    // Frame monitor: pops an expected frame on each accepted handshake and checks every cycle.
    initial begin : mon
      sb_t e;
      bit  go;
      int  fl;
      forever begin
        @(negedge clk);
        if (!rst) begin
          check_eq($sformatf("g%0d idle tx", g), 32'(tx), 32'd1);
          check_eq($sformatf("g%0d idle busy", g), 32'(busy), 32'd0);
          check_eq($sformatf("g%0d idle done", g), 32'(tx_done), 32'd0);
          check_eq($sformatf("g%0d idle ready", g), 32'(u_if.tx_ready), 32'd1);
          go = u_if.tx_valid && u_if.tx_ready;
          while (go) begin
            go = 1'b0;
            check_eq($sformatf("g%0d sb nonempty", g), 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              check_eq($sformatf("g%0d sb inst", g), 32'(e.inst), 32'(g));
              fl = e.nbits * int'(NC);
              for (int c = 0; c < fl; c++) begin
                @(negedge clk);
                if (rst) break;
                check_eq($sformatf("g%0d tx c%0d", g, c), 32'(tx), 32'(e.bits[4'(c / int'(NC))]));
                check_eq($sformatf("g%0d done c%0d", g, c), 32'(tx_done), 32'(c == fl - 1));
                check_eq($sformatf("g%0d busy c%0d", g, c), 32'(busy), 32'd1);
                check_eq($sformatf("g%0d ready c%0d", g, c), 32'(u_if.tx_ready), 32'(c == fl - 1));
                if (c == fl - 1) go = u_if.tx_valid && u_if.tx_ready;
              end
            end
          end
        end
      end
    end
  end

  task automatic send(input int g, input logic [8:0] d, input bit hold);
    int n;
    n = 0;
    sb_q.push_back(build_frame(g, d));
    drv_data[g]  = d;
    drv_valid[g] = 1'b1;
    @(negedge clk);
    while (!mon_ready[g] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("g%0d accept wait", g), 32'(mon_ready[g]), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) drv_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    @(negedge clk);
    while (mon_busy[g] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("g%0d idle wait", g), 32'(mon_busy[g]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    drv_valid = '0;
    for (int g = 0; g < 5; g++) drv_data[g] = '0;
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check_eq($sformatf("rst tx g%0d", g), 32'(mon_tx[g]), 32'd1);
      check_eq($sformatf("rst ready g%0d", g), 32'(mon_ready[g]), 32'd1);
      check_eq($sformatf("rst busy g%0d", g), 32'(mon_busy[g]), 32'd0);
      check_eq($sformatf("rst done g%0d", g), 32'(mon_done[g]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Plain 8N1 frame.
    send(0, 9'h0A5, 1'b0);
    wait_idle(0);

    // Even and odd parity.
    send(1, 9'h007, 1'b0);
    wait_idle(1);
    send(2, 9'h007, 1'b0);
    wait_idle(2);
    for (int k = 0; k < 2; k++) begin
      send(1, 9'($urandom), 1'b0);
      wait_idle(1);
    end

    // Two stop bits, back-to-back with tx_valid held high.
    send(3, 9'h03C, 1'b1);
    send(3, 9'h0C3, 1'b0);
    wait_idle(3);

    // Reset in clk 17 of a frame, then a clean frame.
    send(0, 9'h0F0, 1'b0);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort tx", 32'(mon_tx[0]), 32'd1);
    check_eq("abort ready", 32'(mon_ready[0]), 32'd1);
    check_eq("abort busy", 32'(mon_busy[0]), 32'd0);
    check_eq("abort done", 32'(mon_done[0]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("abort done hold", 32'(mon_done[0]), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 9'h055, 1'b0);
    wait_idle(0);

    // Upstream churn during a frame must not be accepted.
    send(0, 9'h081, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      drv_valid[0] = i[0];
      drv_data[0]  = 9'($urandom);
    end
    drv_valid[0] = 1'b0;
    wait_idle(0);
    check_eq("churn sb drained", 32'(sb_q.size()), 32'd0);

    // Five data bits, two clocks per bit.
    send(4, 9'h01F, 1'b0);
    wait_idle(4);

    repeat (4) @(posedge clk);
    check_eq("final sb drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
